// File: rtl/axil_lite_client_bridge.sv
// AXI4-Lite slave to single-request valid/ready register client bridge, one transaction in flight.
// Optional macro AXIL_CLIENT_SLVERR_EN: illegal write strobes get SLVERR with no client request.
module axil_lite_client_bridge #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  output logic                           v_o,
  input  logic                           ready_and_i,
  output logic [axil_addr_width_p-1:0]   addr_o,
  output logic                           wr_en_o,
  output logic [1:0]                     data_size_o,
  output logic [axil_data_width_p-1:0]   wdata_o,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [axil_data_width_p-1:0]   rdata_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i
);

  localparam int StrbW = axil_data_width_p / 8;
  localparam logic [1:0] FullSize = (axil_data_width_p == 64) ? 2'd3 : 2'd2;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                         state_q;
  logic [axil_addr_width_p-1:0]   addr_q;
  logic [axil_data_width_p-1:0]   wdata_q;
  logic [axil_data_width_p-1:0]   rdata_q;
  logic                           wr_en_q;
  logic [1:0]                     size_q;
  logic                           err_q;

  logic                           strb_legal;
  logic [1:0]                     strb_size;
  logic [63:0]                    grp;
  logic                           wr_accept;

  // Match wstrb against every naturally aligned contiguous group of 2^k lanes.
  always_comb begin
    strb_legal = 1'b0;
    strb_size  = FullSize;
    grp        = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (((i % (1 << k)) == 0) && ((i + (1 << k)) <= StrbW)) begin
          grp = ((64'd1 << (1 << k)) - 64'd1) << i;
          if (s_axil_wstrb_i == grp[StrbW-1:0]) begin
            strb_legal = 1'b1;
            strb_size  = 2'(k);
          end
        end
      end
    end
  end

  assign wr_accept = s_axil_awvalid_i & s_axil_wvalid_i & ~s_axil_arvalid_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_en_q <= 1'b0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axil_arvalid_i) begin
            addr_q  <= s_axil_araddr_i;
            wr_en_q <= 1'b0;
            size_q  <= FullSize;
            err_q   <= 1'b0;
            state_q <= StReq;
          end else if (wr_accept) begin
            addr_q  <= s_axil_awaddr_i;
            wdata_q <= s_axil_wdata_i;
            wr_en_q <= 1'b1;
            size_q  <= strb_size;
`ifdef AXIL_CLIENT_SLVERR_EN
            err_q   <= ~strb_legal;
            state_q <= strb_legal ? StReq : StResp;
`else
            err_q   <= 1'b0;
            state_q <= StReq;
`endif
          end
        end
        StReq:  if (ready_and_i) state_q <= StWait;
        StWait: begin
          if (v_i) begin
            rdata_q <= rdata_i;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (wr_en_q ? s_axil_bready_i : s_axil_rready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign s_axil_arready_o = ~reset_i & (state_q == StIdle);
  assign s_axil_awready_o = ~reset_i & (state_q == StIdle) & wr_accept;
  assign s_axil_wready_o  = s_axil_awready_o;
  assign v_o              = ~reset_i & (state_q == StReq);
  assign ready_and_o      = ~reset_i & (state_q == StWait);
  assign s_axil_rvalid_o  = ~reset_i & (state_q == StResp) & ~wr_en_q;
  assign s_axil_bvalid_o  = ~reset_i & (state_q == StResp) & wr_en_q;
  assign s_axil_rdata_o   = reset_i ? '0 : rdata_q;
  assign s_axil_rresp_o   = 2'b00;
  assign s_axil_bresp_o   = (~reset_i & err_q) ? 2'b10 : 2'b00;

  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign wr_en_o     = wr_en_q;
  assign data_size_o = size_q;

  logic unused_sigs;
  assign unused_sigs = ^{s_axil_awprot_i, s_axil_arprot_i, strb_legal};

endmodule

// File: tb/tb_axil_lite_client_bridge.sv
// Self-checking bench for axil_lite_client_bridge: directed scenarios plus random transactions
// checked against a transaction-level reference model.
module tb_axil_lite_client_bridge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_o, ready_and_i, wr_en_o, v_i, ready_and_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [1:0]  data_size_o;
  logic [31:0] awaddr, wdata, araddr, rdata_o;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_lite_client_bridge dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .v_o             (v_o),
    .ready_and_i     (ready_and_i),
    .addr_o          (addr_o),
    .wr_en_o         (wr_en_o),
    .data_size_o     (data_size_o),
    .wdata_o         (wdata_o),
    .v_i             (v_i),
    .ready_and_o     (ready_and_o),
    .rdata_i         (rdata_i),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (3'b000),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (3'b000),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata_o),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a legal strobe is 2^k contiguous ones starting on a multiple of 2^k.
  function automatic void ref_size(input logic [3:0] strb, output logic [1:0] size,
                                   output bit legal);
    int p = $countones(strb);
    int l = 0;
    while (l < 4 && strb[l] == 1'b0) l++;
    legal = (p != 0) && ((p & (p - 1)) == 0) && (l % (p == 0 ? 1 : p) == 0) &&
            (int'(strb) == (((1 << p) - 1) << l));
    size = legal ? 2'($clog2(p)) : 2'd2;
  endfunction

  function automatic bit slverr_on();
`ifdef AXIL_CLIENT_SLVERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_read(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    #1 chk("ar_accept", arready, 1'b1);
    @(negedge clk); arvalid = 1'b0;
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1 chk("aw_accept", awready, 1'b1);
    chk("w_accept", wready, 1'b1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Entered at the negedge after the accept; returns at the negedge after the R/B handshake.
  task automatic serve(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit err, input logic [31:0] rd,
                       input int rdel, input int bdel);
    if (!err) begin
      #1 chk("req_v", v_o, 1'b1);
      chk("req_addr", addr_o, a);
      chk("req_wr_en", wr_en_o, wr);
      chk("req_size", data_size_o, sz);
      if (wr) chk("req_wdata", wdata_o, wd);
      chk("req_arready", arready, 1'b0);
      chk("req_awready", awready, 1'b0);
      chk("req_ready_and", ready_and_o, 1'b0);
      for (int d = 0; d < rdel; d++) begin
        @(negedge clk);
        #1 chk("hold_v", v_o, 1'b1);
        chk("hold_addr", addr_o, a);
        chk("hold_size", data_size_o, sz);
        chk("hold_arready", arready, 1'b0);
      end
      ready_and_i = 1'b1; v_i = 1'b1; rdata_i = rd;
      @(negedge clk); ready_and_i = 1'b0;
      #1 chk("wait_ready_and", ready_and_o, 1'b1);
      chk("wait_v", v_o, 1'b0);
      @(negedge clk); v_i = 1'b0; rdata_i = $urandom;
    end
    #1 chk("resp_v", v_o, 1'b0);
    chk("resp_arready", arready, 1'b0);
    chk("resp_awready", awready, 1'b0);
    if (wr) begin
      chk("bvalid", bvalid, 1'b1);
      chk("bresp", bresp, err ? 2'b10 : 2'b00);
      chk("rvalid_on_write", rvalid, 1'b0);
    end else begin
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata_o, rd);
      chk("rresp", rresp, 2'b00);
      chk("bvalid_on_read", bvalid, 1'b0);
    end
    for (int d = 0; d < bdel; d++) begin
      @(negedge clk);
      #1 chk("resp_hold_valid", wr ? bvalid : rvalid, 1'b1);
      if (!wr) chk("resp_hold_rdata", rdata_o, rd);
      chk("resp_hold_arready", arready, 1'b0);
    end
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(negedge clk); bready = 1'b0; rready = 1'b0;
    #1 chk("done_valid", rvalid | bvalid, 1'b0);
    chk("done_arready", arready, 1'b1);
  endtask

  initial begin
    logic [1:0] sz;
    bit         legal;
    reset_i = 1'b1; ready_and_i = 1'b0; v_i = 1'b0; rdata_i = '0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_v", v_o, 1'b0);
    chk("rst_ready_and", ready_and_o, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0;
    reset_i = 1'b0;
    @(negedge clk);

    // Basic read and write
    start_read(32'h10);
    serve(1'b0, 32'h10, '0, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0);
    start_write(32'h20, 32'h0000ABCD, 4'b0011);
    serve(1'b1, 32'h20, 32'h0000ABCD, 2'd1, 1'b0, '0, 0, 0);

    // AR, AW and W together: read first, write in the IDLE cycle after R
    araddr = 32'h30; arvalid = 1'b1;
    awaddr = 32'h40; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1 chk("tie_arready", arready, 1'b1);
    chk("tie_awready", awready, 1'b0);
    chk("tie_wready", wready, 1'b0);
    @(negedge clk); arvalid = 1'b0;
    serve(1'b0, 32'h30, '0, 2'd2, 1'b0, 32'hCAFE0001, 1, 1);
    chk("tie_aw_after_r", awready, 1'b1);
    chk("tie_w_after_r", wready, 1'b1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    serve(1'b1, 32'h40, 32'h1234, 2'd2, 1'b0, '0, 0, 0);

    // Backpressure with a second AR held pending throughout
    start_read(32'h50);
    araddr = 32'h54; arvalid = 1'b1;
    serve(1'b0, 32'h50, '0, 2'd2, 1'b0, 32'h55AA55AA, 5, 3);
    @(negedge clk); arvalid = 1'b0;
    serve(1'b0, 32'h54, '0, 2'd2, 1'b0, 32'h0BADF00D, 0, 0);

    // Illegal strobes
    start_write(32'h60, 32'h01020304, 4'b0101);
    serve(1'b1, 32'h60, 32'h01020304, 2'd2, slverr_on(), '0, 0, 0);
    start_write(32'h64, 32'h0A0B0C0D, 4'b0000);
    serve(1'b1, 32'h64, 32'h0A0B0C0D, 2'd2, slverr_on(), '0, 1, 2);
    start_write(32'h68, 32'hFF, 4'b0100);
    serve(1'b1, 32'h68, 32'hFF, 2'd0, 1'b0, '0, 0, 0);

    // Reset pulsed while waiting for the client response
    start_read(32'h70);
    ready_and_i = 1'b1;
    @(negedge clk); ready_and_i = 1'b0;
    #1 chk("pre_rst_wait", ready_and_o, 1'b1);
    reset_i = 1'b1;
    #1 chk("midrst_ready_and", ready_and_o, 1'b0);
    chk("midrst_arready", arready, 1'b0);
    @(negedge clk); reset_i = 1'b0;
    #1 chk("postrst_arready", arready, 1'b1);
    chk("postrst_v", v_o, 1'b0);
    chk("postrst_ready_and", ready_and_o, 1'b0);
    chk("postrst_rvalid", rvalid, 1'b0);
    chk("postrst_bvalid", bvalid, 1'b0);
    @(negedge clk);

    // Random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, d, r;
      logic [3:0]  s;
      int          rdel, bdel;
      a = $urandom & 32'hFFFF_FFFC; d = $urandom; r = $urandom;
      s = 4'($urandom); rdel = $urandom_range(0, 3); bdel = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        ref_size(s, sz, legal);
        start_write(a, d, s);
        serve(1'b1, a, d, sz, slverr_on() && !legal, '0, rdel, bdel);
      end else begin
        start_read(a);
        serve(1'b0, a, '0, 2'd2, 1'b0, r, rdel, bdel);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
